// File: rtl/wb_pkg.sv
// Shared types and width helpers for the wb_ram Wishbone B4 pipelined RAM slave.
package wb_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } wb_state_e;

    // One slot of the termination pipeline
    typedef struct packed {
        logic ack;
        logic err;
        logic rd;
    } wb_term_t;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned byte_off_w(input int unsigned data_w);
        return (data_w > 8) ? $clog2(data_w / 8) : 0;
    endfunction

    function automatic int unsigned word_idx_w(input int unsigned mem_size, input int unsigned data_w);
        int unsigned depth;
        depth = (mem_size * 8) / data_w;
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Synchronous single-port storage with byte-lane writes and read-first behaviour; no reset.
module wb_ram_array
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [DATA_W/8-1:0]      we,
    input  logic [IDX_W-1:0]         idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    localparam int unsigned BPW = bytes_per_word(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Old word is captured before the lane update lands
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            for (int k = 0; k < BPW; k++) begin
                if (we[k]) begin
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wb_ram.sv
// Wishbone B4 pipelined RAM slave with power-up clear sweep.
// Define WB_RAM_OUTREG_EN to add an output register stage (termination latency 2 instead of 1).
module wb_ram
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o,
    output logic                  init_done_o
);

    localparam int unsigned BPW   = bytes_per_word(DATA_W);
    localparam int unsigned DEPTH = (MEM_SIZE * 8) / DATA_W;
    localparam int unsigned IDX_W = word_idx_w(MEM_SIZE, DATA_W);
    localparam int unsigned OFF_W = byte_off_w(DATA_W);
    localparam int unsigned WA_W  = ADDR_W - OFF_W;

    wb_state_e           state_q, state_d;
    logic [IDX_W-1:0]    clr_cnt_q;
    logic                stall_q;
    logic                init_q;
    wb_term_t            t1_q;
    wb_term_t            term_c;
    logic [DATA_W-1:0]   rdata_c;

    logic [WA_W-1:0]     word_adr_c;
    logic                in_range_c;
    logic                accept_c;

    logic                arr_en;
    logic [BPW-1:0]      arr_we;
    logic [IDX_W-1:0]    arr_idx;
    logic [DATA_W-1:0]   arr_wdata;
    logic [DATA_W-1:0]   arr_rdata;

    // Byte-offset bits carry no meaning for a word-wide slave
    logic unused_adr;
    assign unused_adr = ^wb_adr_i;

    assign word_adr_c = wb_adr_i[ADDR_W-1:OFF_W];
    assign in_range_c = (word_adr_c < WA_W'(DEPTH));
    assign accept_c   = wb_cyc_i & wb_stb_i & ~stall_q;

    // Next state and storage port steering
    always_comb begin
        state_d   = state_q;
        arr_en    = 1'b0;
        arr_we    = '0;
        arr_idx   = word_adr_c[IDX_W-1:0];
        arr_wdata = wb_dat_i;
        case (state_q)
            CLEAR: begin
                arr_en    = 1'b1;
                arr_we    = '1;
                arr_idx   = clr_cnt_q;
                arr_wdata = '0;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                arr_en = accept_c & in_range_c;
                arr_we = (accept_c & in_range_c & wb_we_i) ? wb_sel_i : '0;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            stall_q   <= 1'b1;
            init_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= (state_d != READY);
            init_q  <= (state_d == READY);
            if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + IDX_W'(1);
            end
        end
    end

    // First termination stage, aligned with the array read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_q <= '0;
        end else begin
            t1_q.ack <= accept_c & in_range_c;
            t1_q.err <= accept_c & ~in_range_c;
            t1_q.rd  <= ~wb_we_i;
        end
    end

`ifdef WB_RAM_OUTREG_EN
    wb_term_t          t2_q;
    logic [DATA_W-1:0] dat2_q;

    // Terminations in flight are dropped when the master abandons the cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t2_q   <= '0;
            dat2_q <= '0;
        end else begin
            t2_q.ack <= t1_q.ack & wb_cyc_i;
            t2_q.err <= t1_q.err & wb_cyc_i;
            t2_q.rd  <= t1_q.rd;
            dat2_q   <= (t1_q.ack & t1_q.rd) ? arr_rdata : '0;
        end
    end

    assign term_c  = t2_q;
    assign rdata_c = dat2_q;
`else
    assign term_c  = t1_q;
    assign rdata_c = arr_rdata;
`endif

    assign wb_ack_o    = term_c.ack & wb_cyc_i;
    assign wb_err_o    = term_c.err & wb_cyc_i;
    assign wb_dat_o    = (wb_ack_o & term_c.rd) ? rdata_c : '0;
    assign wb_stall_o  = stall_q;
    assign init_done_o = init_q;

    wb_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule
